// File: rtl/lsi_frame_seq.sv
// Frame sequencer: walks a chain of run/valid stages once per completed input
// frame, with per-stage timeout, frame counting and per-frame cycle measurement.
module lsi_frame_seq #(
  parameter int N_STAGE = 4,
  parameter int TIMEOUT = 1024,
  parameter int STAGE_W = 2
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               en,
  input  logic               in_last,
  input  logic               out_last,
  input  logic [N_STAGE-1:0] valid,
  input  logic               clr_err,
  output logic [N_STAGE-1:0] run,
  output logic               busy,
  output logic [STAGE_W-1:0] stage,
  output logic               err,
  output logic [STAGE_W-1:0] err_stage,
  output logic               drop,
  output logic [15:0]        frame_cnt,
  output logic [31:0]        cyc_cnt
);

  // Handshake: run[k] is a level held from RUN(k) entry until valid[k] is
  // sampled high; in_last/out_last are single-cycle completed-handshake pulses.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_WAIT,
    S_ERR
  } state_t;

  localparam logic [STAGE_W-1:0] LAST_STG = STAGE_W'(N_STAGE - 1);
  localparam logic [31:0]        TMO_LIM  = 32'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [STAGE_W-1:0]   stg_q, stg_d;
  logic [STAGE_W-1:0]   err_stg_q, err_stg_d;
  logic                 pend_q, pend_d;
  logic                 drop_q, drop_d;
  logic [31:0]          tmo_q, tmo_d;
  logic [31:0]          fcyc_q, fcyc_d;
  logic [31:0]          fcyc_inc;
  logic [15:0]          frame_q, frame_d;
  logic [31:0]          cyc_q, cyc_d;
  logic [N_STAGE-1:0]   run_q, run_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 tmo_hit;

  always_comb begin
    state_d   = state_q;
    stg_d     = stg_q;
    err_stg_d = err_stg_q;
    pend_d    = pend_q | in_last;
    drop_d    = drop_q | (in_last & pend_q);
    frame_d   = frame_q;
    cyc_d     = cyc_q;
    tmo_d     = '0;
    fcyc_d    = '0;
    fcyc_inc  = (fcyc_q == '1) ? fcyc_q : fcyc_q + 32'd1;
    tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_LIM);

    case (state_q)
      S_IDLE: begin
        // A same-cycle in_last is consumed by the start, not queued.
        if (en && (pend_q || in_last)) begin
          state_d = S_RUN;
          stg_d   = '0;
          pend_d  = 1'b0;
        end
      end
      S_RUN: begin
        fcyc_d = fcyc_inc;
        if (valid[stg_q]) begin
          state_d = (stg_q == LAST_STG) ? S_WAIT : S_GAP;
        end else if (tmo_hit) begin
          state_d   = S_ERR;
          err_stg_d = stg_q;
          fcyc_d    = '0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_GAP: begin
        fcyc_d  = fcyc_inc;
        state_d = S_RUN;
        stg_d   = stg_q + STAGE_W'(1);
      end
      S_WAIT: begin
        if (out_last) begin
          state_d = S_IDLE;
          frame_d = frame_q + 16'd1;
          cyc_d   = fcyc_inc;
        end else begin
          fcyc_d = fcyc_inc;
        end
      end
      S_ERR: begin
        if (clr_err) begin
          state_d = S_IDLE;
          pend_d  = in_last;
        end
      end
      default: state_d = S_IDLE;
    endcase

    run_d = '0;
    if (state_d == S_RUN) run_d[stg_d] = 1'b1;
    busy_d = (state_d != S_IDLE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      stg_q     <= '0;
      err_stg_q <= '0;
      pend_q    <= 1'b0;
      drop_q    <= 1'b0;
      tmo_q     <= '0;
      fcyc_q    <= '0;
      frame_q   <= '0;
      cyc_q     <= '0;
      run_q     <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stg_q     <= stg_d;
      err_stg_q <= err_stg_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      tmo_q     <= tmo_d;
      fcyc_q    <= fcyc_d;
      frame_q   <= frame_d;
      cyc_q     <= cyc_d;
      run_q     <= run_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign run       = run_q;
  assign busy      = busy_q;
  assign stage     = stg_q;
  assign err       = err_q;
  assign err_stage = err_stg_q;
  assign drop      = drop_q;
  assign frame_cnt = frame_q;
  assign cyc_cnt   = cyc_q;

endmodule

// File: tb/tb_lsi_frame_seq.sv
// Bench for lsi_frame_seq: vector tables, directed corner sequences and random
// stimulus, all checked against a frame-level reference model.
module tb_lsi_frame_seq;
  localparam int N   = 4;
  localparam int TMO = 16;
  localparam int SW  = 2;
  localparam longint MAXC = 64'hFFFF_FFFF;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          en = 1'b0;
  logic          in_last = 1'b0;
  logic          out_last = 1'b0;
  logic [N-1:0]  valid = '0;
  logic          clr_err = 1'b0;
  logic [N-1:0]  run;
  logic          busy;
  logic [SW-1:0] stage;
  logic          err;
  logic [SW-1:0] err_stage;
  logic          drop;
  logic [15:0]   frame_cnt;
  logic [31:0]   cyc_cnt;

  lsi_frame_seq #(.N_STAGE(N), .TIMEOUT(TMO), .STAGE_W(SW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .en(en), .in_last(in_last),
    .out_last(out_last), .valid(valid), .clr_err(clr_err), .run(run),
    .busy(busy), .stage(stage), .err(err), .err_stage(err_stage),
    .drop(drop), .frame_cnt(frame_cnt), .cyc_cnt(cyc_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 ACLK = ~ACLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [47:0] exp_q[$];
  logic [15:0] prev_fc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is a walk over positions: 2k = running stage k, 2k+1 = gap after
  // stage k, 2N-1 = waiting for the output TLAST.
  bit     m_active, m_err, m_pending, m_drop;
  int     m_pos, m_age, m_stage, m_err_stage, m_frames;
  longint m_len, m_cyc;

  task automatic model_reset();
    m_active = 0; m_err = 0; m_pending = 0; m_drop = 0;
    m_pos = 0; m_age = 0; m_stage = 0; m_err_stage = 0; m_frames = 0;
    m_len = 0; m_cyc = 0;
  endtask

  task automatic model_step(input logic e, input logic il, input logic ol,
                            input logic [N-1:0] vl, input logic ce);
    bit pend_old;
    bit started;
    bit cleared;
    int k;
    logic [47:0] rec;
    pend_old = m_pending;
    started  = 0;
    cleared  = 0;
    if (m_err) begin
      if (ce) begin m_err = 0; cleared = 1; end
    end else if (!m_active) begin
      if (e && (pend_old || il)) begin
        m_active = 1; m_pos = 0; m_age = 0; m_len = 0; started = 1;
      end
    end else begin
      m_len++;
      if (m_pos == 2*N-1) begin
        if (ol) begin
          m_frames = (m_frames + 1) % 65536;
          m_cyc = (m_len > MAXC) ? MAXC : m_len;
          m_active = 0;
          m_len = 0;
          rec = {m_frames[15:0], m_cyc[31:0]};
          exp_q.push_back(rec);
        end
      end else if (m_pos % 2 == 0) begin
        k = m_pos / 2;
        if (vl[k]) begin
          m_pos++; m_age = 0;
        end else if (TMO != 0 && m_age == TMO-1) begin
          m_err = 1; m_err_stage = k; m_active = 0; m_len = 0;
        end else begin
          m_age++;
        end
      end else begin
        m_pos++; m_age = 0;
      end
    end
    if (m_active) m_stage = m_pos / 2;
    if (il && pend_old) m_drop = 1;
    m_pending = started ? 1'b0 : (cleared ? il : (pend_old | il));
  endtask

  function automatic logic [N-1:0] m_run();
    logic [N-1:0] r;
    r = '0;
    if (m_active && (m_pos % 2 == 0)) r[m_pos/2] = 1'b1;
    return r;
  endfunction

  task automatic compare_all();
    logic [47:0] rec;
    check("run", run, m_run());
    check("busy", busy, m_active || m_err);
    check("stage", stage, m_stage);
    check("err", err, m_err);
    check("err_stage", err_stage, m_err_stage);
    check("drop", drop, m_drop);
    check("frame_cnt", frame_cnt, m_frames);
    check("cyc_cnt", cyc_cnt, m_cyc[31:0]);
    if (frame_cnt !== prev_fc) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_frame: got frame_cnt 0x%0h with no completion expected", frame_cnt);
      end else begin
        rec = exp_q.pop_front();
        check("sb_completion", {frame_cnt, cyc_cnt}, rec);
      end
      prev_fc = frame_cnt;
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic e, input logic il, input logic ol,
                      input logic [N-1:0] vl, input logic ce);
    en = e; in_last = il; out_last = ol; valid = vl; clr_err = ce;
    @(posedge ACLK);
    model_step(e, il, ol, vl, ce);
    #1;
    compare_all();
  endtask

  // From GAP(k0-1): run stages k0..N-1 with single-cycle valids, then out_last.
  task automatic finish_frame(input int k0);
    for (int k = k0; k < N; k++) begin
      tick(1, 0, 0, '0, 0);
      tick(1, 0, 0, N'(1 << k), 0);
    end
    tick(1, 0, 1, '0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         il;
    logic         ol;
    logic [N-1:0] vl;
    logic [N-1:0] x_run;
    logic         x_busy;
  } vec_t;
  vec_t tbl[$];

  task automatic push_vec(input logic il, input logic ol, input logic [N-1:0] vl,
                          input logic [N-1:0] xr, input logic xb);
    vec_t v;
    v.il = il; v.ol = ol; v.vl = vl; v.x_run = xr; v.x_busy = xb;
    tbl.push_back(v);
  endtask

  // Each stage asserts valid in its 3rd run cycle; out_last in 2nd WAIT cycle.
  // With stray set, valid[3] is shown during stage 0 and out_last during stage 2.
  task automatic build_table(input bit stray);
    logic [N-1:0] sv;
    logic         so;
    tbl.delete();
    push_vec(1, 0, '0, N'(1), 1);
    for (int k = 0; k < N; k++) begin
      for (int r = 0; r < 2; r++) begin
        sv = (stray && k == 0) ? N'(8) : '0;
        so = stray && (k == 2);
        push_vec(0, so, sv, N'(1 << k), 1);
      end
      push_vec(0, 0, N'(1 << k), '0, 1);
      if (k < N-1) push_vec(0, 0, '0, N'(1 << (k+1)), 1);
    end
    push_vec(0, 0, '0, '0, 1);
    push_vec(0, 1, '0, '0, 0);
  endtask

  task automatic apply_table(input string tag);
    foreach (tbl[i]) begin
      tick(1, tbl[i].il, tbl[i].ol, tbl[i].vl, 0);
      check({tag, "_run"}, run, tbl[i].x_run);
      check({tag, "_busy"}, busy, tbl[i].x_busy);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int hi;
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
    compare_all();
    ARESET = 1'b0;

    // Nominal frame
    build_table(0);
    apply_table("nominal");
    check("nominal_frame_cnt", frame_cnt, 1);
    check("nominal_cyc_cnt", cyc_cnt, 17);

    // Stray valid / out_last are ignored
    tick(1, 0, 0, '0, 0);
    build_table(1);
    apply_table("stray");
    check("stray_frame_cnt", frame_cnt, 2);
    check("stray_cyc_cnt", cyc_cnt, 17);

    // Timeout on stage 1
    tick(1, 1, 0, '0, 0);
    tick(1, 0, 0, N'(1), 0);
    tick(1, 0, 0, '0, 0);
    hi = (run == N'(2)) ? 1 : 0;
    for (int i = 0; i < 40 && err !== 1'b1; i++) begin
      tick(1, 0, 0, '0, 0);
      if (run == N'(2)) hi++;
    end
    check("tmo_run_cycles", hi, 16);
    check("tmo_err", err, 1);
    check("tmo_err_stage", err_stage, 1);
    check("tmo_run_zero", run, 0);
    tick(1, 0, 0, '0, 1);
    check("tmo_clr_busy", busy, 0);
    check("tmo_frame_cnt", frame_cnt, 2);
    check("tmo_cyc_cnt", cyc_cnt, 17);

    // Timeout boundary: valid in the 16th run cycle wins
    tick(1, 1, 0, '0, 0);
    for (int i = 0; i < TMO-1; i++) tick(1, 0, 0, '0, 0);
    tick(1, 0, 0, N'(1), 0);
    check("bound_err", err, 0);
    check("bound_gap_run", run, 0);
    check("bound_busy", busy, 1);
    finish_frame(1);
    check("bound_frame_cnt", frame_cnt, 3);

    // Queuing and drop
    tick(1, 1, 0, '0, 0);
    tick(1, 0, 0, N'(1), 0);
    tick(1, 0, 0, '0, 0);
    tick(1, 1, 0, '0, 0);
    tick(1, 0, 0, N'(2), 0);
    finish_frame(2);
    check("queue_idle", busy, 0);
    tick(1, 0, 0, '0, 0);
    check("queue_start", run, 1);
    tick(1, 0, 0, N'(1), 0);
    tick(1, 1, 0, '0, 0);
    tick(1, 1, 0, '0, 0);
    check("queue_drop", drop, 1);
    tick(1, 0, 0, N'(2), 0);
    finish_frame(2);
    tick(1, 0, 0, '0, 0);
    check("queue_third_start", run, 1);
    tick(1, 0, 0, N'(1), 0);
    finish_frame(1);
    tick(1, 0, 0, '0, 0);
    check("queue_no_fourth", busy, 0);
    check("queue_frame_cnt", frame_cnt, 6);

    // Gating by en
    tick(0, 1, 0, '0, 0);
    tick(0, 0, 0, '0, 0);
    tick(0, 0, 0, '0, 0);
    check("gate_held", busy, 0);
    tick(1, 0, 0, '0, 0);
    check("gate_start", run, 1);
    tick(1, 0, 0, N'(1), 0);
    finish_frame(1);
    check("gate_frame_cnt", frame_cnt, 7);

    // Asynchronous reset in RUN(2)
    tick(1, 1, 0, '0, 0);
    tick(1, 0, 0, N'(1), 0);
    tick(1, 0, 0, '0, 0);
    tick(1, 0, 0, N'(2), 0);
    tick(1, 0, 0, '0, 0);
    check("rst_pre_run", run, 4);
    #2;
    ARESET = 1'b1;
    #1;
    check("rst_async_run", run, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_frame_cnt", frame_cnt, 0);
    check("rst_async_drop", drop, 0);
    model_reset();
    exp_q.delete();
    prev_fc = '0;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    tick(0, 0, 0, '0, 0);
    check("rst_idle", busy, 0);

    // Random stimulus against the model
    for (int blk = 0; blk < 15; blk++) begin
      int vp;
      vp = (blk % 3 == 0) ? 40 : ((blk % 3 == 1) ? 2 : 5);
      for (int i = 0; i < 200; i++) begin
        logic [N-1:0] v;
        for (int b = 0; b < N; b++) v[b] = ($urandom_range(0, vp) == 0);
        tick($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) == 0, v, $urandom_range(0, 5) == 0);
      end
    end

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
